vsc_mem_responder: RTL and testbench

Memory-side responder for the VerySimpleCPU RAM bus: a single-port, read-first word memory that answers the CPU's address/write-enable/data requests with one-cycle registered read latency. On reset it first runs a loader phase that streams a program image in over a valid/ready port while holding the CPU in reset, then releases the CPU. One word address is also decoded as a memory-mapped output register with a strobe, giving benches and the top level a visible program result.

---
 rtl/vsc_pkg.sv | 22 ++
 rtl/vsc_spram.sv | 24 ++
 rtl/vsc_mem_responder.sv | 137 +++++++++++++
 tb/tb_vsc_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vsc_pkg.sv
// Shared definitions for the VerySimpleCPU memory side, the CPU and their benches.
package vsc_pkg;

    // Default bus geometry.
    localparam int VSC_WORD_W = 32;
    localparam int VSC_SIZE   = 14;

    // Responder FSM state encodings.
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // VerySimpleCPU opcodes, instruction bits [31:29] (bit 28 selects the immediate form).
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_CP   = 3'd4;
    localparam logic [2:0] OP_CPI  = 3'd5;
    localparam logic [2:0] OP_BZJ  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

endpackage

// File: rtl/vsc_spram.sv
// Single-port word RAM with registered, read-first synchronous read.
// The array has no reset, so contents survive a controller reset.
module vsc_spram #(
    parameter int SIZE   = 14,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [SIZE-1:0]   addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(2**SIZE)-1];

    // Read returns the pre-write contents when the same address is written on this edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vsc_mem_responder.sv
// RAM-bus responder for VerySimpleCPU: loads a program image over a valid/ready
// port while holding the CPU in reset, then serves CPU reads/writes and mirrors
// writes to IO_ADDR onto io_out with a one-cycle strobe.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_LOAD | accept loader words into consecutive addresses, CPU held
//   ST_RUN  | CPU owns the RAM port, loader ignored
module vsc_mem_responder
    import vsc_pkg::*;
#(
    parameter int SIZE    = VSC_SIZE,
    parameter int WORD_W  = VSC_WORD_W,
    parameter int IO_ADDR = (2**SIZE) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   addr_toRAM,
    input  logic              wrEn,
    input  logic [WORD_W-1:0] data_toRAM,
    output logic [WORD_W-1:0] data_fromRAM,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_rst,
    output logic              load_done,
    output logic [SIZE:0]     ld_count,
    output logic [WORD_W-1:0] io_out,
    output logic              io_strobe
);

    localparam logic [SIZE-1:0] IO_A = IO_ADDR[SIZE-1:0];

    logic [0:0]        state_q;
    logic [0:0]        state_nxt;
    logic [SIZE-1:0]   ld_addr_q;
    logic              ld_xfer;
    logic              ld_final;
    logic              run;
    logic              io_hit;
    logic              rd_valid_q;
    logic              ram_we;
    logic [SIZE-1:0]   ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    assign run      = (state_q == ST_RUN);
    assign ld_xfer  = !run && ld_valid;
    // A transfer into the top address fills the image and ends the load without wrapping.
    assign ld_final = ld_xfer && (ld_last || (ld_addr_q == '1));
    assign io_hit   = run && wrEn && (addr_toRAM == IO_A);

    // Next state: leave LOAD on the final loader transfer; RUN is held until rst.
    always_comb begin
        state_nxt = state_q;
        if (ld_final) begin
            state_nxt = ST_RUN;
        end
    end

    // RAM port ownership: loader during LOAD, CPU bus during RUN.
    always_comb begin
        ram_we    = ld_xfer;
        ram_addr  = ld_addr_q;
        ram_wdata = ld_data;
        if (run) begin
            ram_we    = wrEn;
            ram_addr  = addr_toRAM;
            ram_wdata = data_toRAM;
        end
    end

    // State register and its registered decodes (ld_ready depends on state only).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            ld_ready  <= 1'b1;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            ld_ready  <= (state_nxt == ST_LOAD);
            cpu_rst   <= (state_nxt == ST_LOAD);
            load_done <= (state_nxt == ST_RUN);
        end
    end

    // Loader write pointer and accepted-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_addr_q <= '0;
            ld_count  <= '0;
        end else if (ld_xfer) begin
            ld_count <= ld_count + 1'b1;
            if (!ld_final) begin
                ld_addr_q <= ld_addr_q + 1'b1;
            end
        end
    end

    // Read data is only shown to the CPU for reads issued in RUN; loader-phase reads return 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= run;
        end
    end

    assign data_fromRAM = rd_valid_q ? ram_rdata : '0;

    // Memory-mapped output register and its write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_out    <= '0;
            io_strobe <= 1'b0;
        end else begin
            io_strobe <= io_hit;
            if (io_hit) begin
                io_out <= data_toRAM;
            end
        end
    end

    vsc_spram #(
        .SIZE   (SIZE),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_vsc_mem_responder.sv
// Directed bench for vsc_mem_responder: a default-size instance for load, RUN
// read/write and IO checks, and a SIZE=4 instance for the full-image case.
module tb_vsc_mem_responder;

    localparam int SZ   = 14;
    localparam int SZ4  = 4;
    localparam int IOA  = (2**SZ) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [SZ-1:0] addr_toRAM = '0;
    logic          wrEn = 1'b0;
    logic [31:0]   data_toRAM = '0;
    logic [31:0]   data_fromRAM;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready, cpu_rst, load_done, io_strobe;
    logic [SZ:0]   ld_count;
    logic [31:0]   io_out;

    logic [SZ4-1:0] s4_addr = '0;
    logic           s4_wren = 1'b0;
    logic [31:0]    s4_wdata = '0;
    logic [31:0]    s4_rdata;
    logic           s4_ld_valid = 1'b0;
    logic [31:0]    s4_ld_data = '0;
    logic           s4_ld_last = 1'b0;
    logic           s4_ld_ready, s4_cpu_rst, s4_load_done, s4_io_strobe;
    logic [SZ4:0]   s4_ld_count;
    logic [31:0]    s4_io_out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vsc_mem_responder #(.SIZE(SZ), .WORD_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .addr_toRAM(addr_toRAM), .wrEn(wrEn), .data_toRAM(data_toRAM),
        .data_fromRAM(data_fromRAM),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_rst(cpu_rst), .load_done(load_done), .ld_count(ld_count),
        .io_out(io_out), .io_strobe(io_strobe)
    );

    vsc_mem_responder #(.SIZE(SZ4), .WORD_W(32)) u_dut4 (
        .clk(clk), .rst(rst),
        .addr_toRAM(s4_addr), .wrEn(s4_wren), .data_toRAM(s4_wdata),
        .data_fromRAM(s4_rdata),
        .ld_valid(s4_ld_valid), .ld_data(s4_ld_data), .ld_last(s4_ld_last), .ld_ready(s4_ld_ready),
        .cpu_rst(s4_cpu_rst), .load_done(s4_load_done), .ld_count(s4_ld_count),
        .io_out(s4_io_out), .io_strobe(s4_io_strobe)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_cycle(input logic [SZ-1:0] a, input logic we, input logic [31:0] d);
        addr_toRAM = a;
        wrEn       = we;
        data_toRAM = d;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        check_val("rst_ld_ready", ld_ready, 1);
        check_val("rst_cpu_rst", cpu_rst, 1);
        check_val("rst_load_done", load_done, 0);
        check_val("rst_ld_count", ld_count, 0);
        check_val("rst_io_out", io_out, 0);
        check_val("rst_io_strobe", io_strobe, 0);
        check_val("rst_rdata", data_fromRAM, 0);
        rst = 1'b0;
        step();

        // Two words, then reset mid-load
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hBBBB_0001 + i;
            ld_last  = 1'b0;
            addr_toRAM = SZ'(i);
            wrEn     = 1'b1;
            step();
            check_val("part_ld_count", ld_count, 64'(i + 1));
            check_val("load_rdata_zero", data_fromRAM, 0);
            check_val("load_no_io", io_strobe, 0);
        end
        wrEn     = 1'b0;
        ld_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("midrst_ld_count", ld_count, 0);
        check_val("midrst_cpu_rst", cpu_rst, 1);
        check_val("midrst_ld_ready", ld_ready, 1);
        check_val("midrst_load_done", load_done, 0);
        step();

        // Reload 4 words with a gap cycle between valid cycles
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hAAAA_0001 + i;
            ld_last  = (i == 3);
            if (i == 3) check_val("last_cycle_cpu_rst", cpu_rst, 1);
            step();
            check_val("gap_ld_count", ld_count, 64'(i + 1));
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            ld_data  = 32'hDEAD_BEEF;
            if (i < 3) begin
                step();
                check_val("gap_hold_count", ld_count, 64'(i + 1));
                check_val("gap_still_load", cpu_rst, 1);
            end
        end
        check_val("run_cpu_rst", cpu_rst, 0);
        check_val("run_load_done", load_done, 1);
        check_val("run_ld_ready", ld_ready, 0);

        // RUN reads of the image, loader valid held high and ignored
        ld_valid = 1'b1;
        ld_data  = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            cpu_cycle(SZ'(i), 1'b0, 32'h0);
            check_val("run_read_img", data_fromRAM, 64'(32'hAAAA_0001 + i));
        end
        check_val("run_count_frozen", ld_count, 4);
        ld_valid = 1'b0;

        // Read-first on a same-cycle write
        cpu_cycle(SZ'(5), 1'b1, 32'h1111_0000);
        cpu_cycle(SZ'(5), 1'b1, 32'h1234_5678);
        check_val("same_cycle_old", data_fromRAM, 32'h1111_0000);
        cpu_cycle(SZ'(5), 1'b0, 32'h0);
        check_val("next_cycle_new", data_fromRAM, 32'h1234_5678);
        check_val("plain_write_no_io", io_strobe, 0);

        // IO register and strobe
        cpu_cycle(SZ'(IOA), 1'b1, 32'h0000_002A);
        check_val("io_out_2a", io_out, 32'h2A);
        check_val("io_strobe_on", io_strobe, 1);
        cpu_cycle(SZ'(IOA), 1'b0, 32'h0);
        check_val("io_strobe_off", io_strobe, 0);
        check_val("io_mem_written", data_fromRAM, 32'h2A);
        cpu_cycle(SZ'(IOA - 1), 1'b1, 32'h0000_0055);
        check_val("io_m1_no_strobe", io_strobe, 0);
        check_val("io_m1_hold", io_out, 32'h2A);
        cpu_cycle(SZ'(IOA), 1'b1, 32'h0000_0001);
        check_val("b2b_strobe1", io_strobe, 1);
        check_val("b2b_out1", io_out, 1);
        cpu_cycle(SZ'(IOA), 1'b1, 32'h0000_0002);
        check_val("b2b_strobe2", io_strobe, 1);
        check_val("b2b_out2", io_out, 2);
        cpu_cycle(SZ'(IOA - 1), 1'b0, 32'h0);
        check_val("b2b_strobe_end", io_strobe, 0);
        check_val("io_m1_mem", data_fromRAM, 32'h55);

        // Full image on the SIZE=4 instance, no ld_last
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("s4_rst_count", s4_ld_count, 0);
        for (int i = 0; i < 16; i++) begin
            s4_ld_valid = 1'b1;
            s4_ld_data  = 32'hC000_0000 + i;
            s4_ld_last  = 1'b0;
            step();
            if (i == 14) begin
                check_val("s4_15_ready", s4_ld_ready, 1);
                check_val("s4_15_count", s4_ld_count, 15);
            end
        end
        check_val("s4_full_count", s4_ld_count, 16);
        check_val("s4_full_ready", s4_ld_ready, 0);
        check_val("s4_full_done", s4_load_done, 1);
        check_val("s4_full_cpu_rst", s4_cpu_rst, 0);
        s4_ld_data = 32'hDEAD_0000;
        step();
        check_val("s4_count_frozen", s4_ld_count, 16);
        s4_ld_valid = 1'b0;
        s4_addr = 4'd0;
        step();
        check_val("s4_no_wrap_0", s4_rdata, 32'hC000_0000);
        s4_addr = 4'd15;
        step();
        check_val("s4_last_word", s4_rdata, 32'hC000_000F);
        s4_addr = 4'd7;
        step();
        check_val("s4_mid_word", s4_rdata, 32'hC000_0007);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
